clk_div_counter: RTL and testbench

- Top-level of the clock-divider demo.
- Divides the 50 MHz board clock down to a 1 Hz rate. The rate drives a registered 1 Hz square-wave output and a one-cycle enable tick.
- The tick advances a 3-bit free-running up-counter when counting is enabled.
- Single clock domain: the divided rate is a clock enable, never a derived clock for internal logic.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_counter_if.sv | 15 +
 rtl/clk_divider.sv | 43 ++++
 rtl/clk_div_counter.sv | 44 ++++
 tb/tb_clk_div_counter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the clock-divider demo: board/output rates and the
// derived divide ratio, plus the prescaler width helper.
package clk_div_pkg;

  localparam int unsigned CLK_IN_HZ_DEF  = 32'd50_000_000;
  localparam int unsigned CLK_OUT_HZ_DEF = 32'd1;
  localparam int unsigned DIV_DEF        = CLK_IN_HZ_DEF / CLK_OUT_HZ_DEF;
  localparam int unsigned HALF_DIV       = DIV_DEF / 32'd2;
  localparam int unsigned COUNT_W_DEF    = 32'd3;

  // A half-period of one cycle still needs a 1-bit prescaler register.
  function automatic int unsigned presc_width(input int unsigned div);
    int unsigned half;
    half = div / 32'd2;
    if (half > 32'd1) begin
      return $clog2(half);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/clk_div_counter_if.sv
// Enable/status bundle of the clock-divider demo; the block uses the slave view.
interface clk_div_counter_if
  import clk_div_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF
);

  logic               enable_counter;
  logic               clk_1Hz;
  logic [COUNT_W-1:0] out_counter;

  modport master (output enable_counter, input clk_1Hz, input out_counter);
  modport slave  (input enable_counter, output clk_1Hz, output out_counter);

endinterface

// File: rtl/clk_divider.sv
// Prescaler producing a 50% duty square wave of period DIV cycles and a
// one-cycle tick qualifying the edge on which that square wave rises.
module clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF
) (
  input  logic clk_50MHz,
  input  logic reset_clk,
  output logic clk_1Hz,
  output logic tick
);

  localparam int unsigned HALF = DIV / 32'd2;
  localparam int unsigned PW   = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(HALF - 32'd1);

  logic [PW-1:0] presc_r;
  logic          clk_r;
  logic          wrap_s;

  assign wrap_s = (presc_r == LAST);

  // Half-period prescaler; the square wave flips each time it wraps.
  always_ff @(posedge clk_50MHz or negedge reset_clk) begin
    if (!reset_clk) begin
      presc_r <= '0;
      clk_r   <= 1'b0;
    end else if (wrap_s) begin
      presc_r <= '0;
      clk_r   <= ~clk_r;
    end else begin
      presc_r <= presc_r + PW'(1);
      clk_r   <= clk_r;
    end
  end

  // Tick is decoded from registered state so the counter updates on the
  // same edge where clk_1Hz rises; gating with reset keeps it quiet in reset.
  assign tick    = reset_clk & wrap_s & ~clk_r;
  assign clk_1Hz = clk_r;

endmodule

// File: rtl/clk_div_counter.sv
// Top of the clock-divider demo: divider plus a tick-enabled wrapping counter,
// all in the single clk_50MHz domain.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned CLK_IN_HZ  = CLK_IN_HZ_DEF,
  parameter int unsigned CLK_OUT_HZ = CLK_OUT_HZ_DEF,
  parameter int unsigned DIV        = CLK_IN_HZ / CLK_OUT_HZ,
  parameter int unsigned COUNT_W    = COUNT_W_DEF
) (
  input  logic              clk_50MHz,
  input  logic              reset_clk,
  input  logic              reset_counter,
  clk_div_counter_if.slave  bus
);

  logic               tick_s;
  logic               clk_1hz_s;
  logic [COUNT_W-1:0] count_r;

  clk_divider #(
    .DIV (DIV)
  ) u_divider (
    .clk_50MHz (clk_50MHz),
    .reset_clk (reset_clk),
    .clk_1Hz   (clk_1hz_s),
    .tick      (tick_s)
  );

  // Enable is only looked at on tick edges; the count wraps silently.
  always_ff @(posedge clk_50MHz or negedge reset_counter) begin
    if (!reset_counter) begin
      count_r <= '0;
    end else if (tick_s && bus.enable_counter) begin
      count_r <= count_r + COUNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.clk_1Hz     = clk_1hz_s;
  assign bus.out_counter = count_r;

endmodule

// File: tb/tb_clk_div_counter.sv
// Self-checking bench for clk_div_counter at DIV=10, plus a default-ratio
// instance that must stay silent over a long run.
module tb_clk_div_counter;

  localparam int unsigned TDIV  = 32'd10;
  localparam int unsigned THALF = 32'd5;

  typedef enum int {OP_RUN, OP_RSTCNT, OP_RSTCLK} op_e;

  typedef struct {
    op_e        op;
    logic       en;
    int         ncyc;
    logic [2:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic       clk_1hz;
    logic [2:0] cnt;
  } exp_t;

  logic clk     = 1'b0;
  logic rst_clk = 1'b1;
  logic rst_cnt = 1'b1;

  int         compared   = 0;
  int         mismatched = 0;
  int         k_m        = 0;
  logic [2:0] cnt_m      = 3'd0;
  int         dflt_edges = 0;
  exp_t       sb_q[$];
  vec_t       vecs[14];

  clk_div_counter_if #(.COUNT_W(3)) bus ();
  clk_div_counter_if #(.COUNT_W(3)) dflt_bus ();

  clk_div_counter #(.DIV(TDIV), .COUNT_W(3)) dut (
    .clk_50MHz     (clk),
    .reset_clk     (rst_clk),
    .reset_counter (rst_cnt),
    .bus           (bus)
  );

  clk_div_counter dflt (
    .clk_50MHz     (clk),
    .reset_clk     (rst_clk),
    .reset_counter (rst_cnt),
    .bus           (dflt_bus)
  );

  always #5 clk = ~clk;

  always @(posedge dflt_bus.clk_1Hz) dflt_edges++;

  function automatic logic model_clk();
    if (!rst_clk) return 1'b0;
    return ((k_m / THALF) % 2) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the reference model, queue its prediction, then
  // compare the DUT just after the edge.
  task automatic run_cycle(input logic en);
    exp_t e;
    bus.enable_counter = en;
    if (rst_clk) k_m++;
    else k_m = 0;
    if (rst_clk && rst_cnt && en && ((k_m % TDIV) == THALF)) cnt_m++;
    if (!rst_cnt) cnt_m = 3'd0;
    e.clk_1hz = model_clk();
    e.cnt     = cnt_m;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("clk_1Hz", {31'd0, bus.clk_1Hz}, {31'd0, e.clk_1hz});
    check("out_counter", {29'd0, bus.out_counter}, {29'd0, e.cnt});
  endtask

  initial begin
    vecs[0]  = '{OP_RUN,    1'b1, 25, 3'd3};
    vecs[1]  = '{OP_RUN,    1'b1, 50, 3'd0};
    vecs[2]  = '{OP_RUN,    1'b0, 20, 3'd0};
    vecs[3]  = '{OP_RUN,    1'b1,  1, 3'd0};
    vecs[4]  = '{OP_RUN,    1'b0,  8, 3'd0};
    vecs[5]  = '{OP_RUN,    1'b1,  1, 3'd1};
    vecs[6]  = '{OP_RUN,    1'b0,  9, 3'd1};
    vecs[7]  = '{OP_RUN,    1'b1, 40, 3'd5};
    vecs[8]  = '{OP_RSTCNT, 1'b1,  0, 3'd0};
    vecs[9]  = '{OP_RUN,    1'b1, 13, 3'd2};
    vecs[10] = '{OP_RSTCLK, 1'b1,  3, 3'd2};
    vecs[11] = '{OP_RUN,    1'b1,  4, 3'd2};
    vecs[12] = '{OP_RUN,    1'b1,  1, 3'd3};
    vecs[13] = '{OP_RUN,    1'b1, 10, 3'd4};

    bus.enable_counter      = 1'b0;
    dflt_bus.enable_counter = 1'b1;

    // Power-up: outputs must clear before any clock edge arrives.
    #2;
    rst_clk = 1'b0;
    rst_cnt = 1'b0;
    #1;
    check("por_clk_1Hz", {31'd0, bus.clk_1Hz}, 32'd0);
    check("por_out_counter", {29'd0, bus.out_counter}, 32'd0);
    repeat (3) run_cycle(1'b1);
    rst_clk = 1'b1;
    rst_cnt = 1'b1;

    for (int i = 0; i < 14; i++) begin
      case (vecs[i].op)
        OP_RUN: begin
          repeat (vecs[i].ncyc) run_cycle(vecs[i].en);
        end
        OP_RSTCNT: begin
          #3;
          rst_cnt = 1'b0;
          cnt_m   = 3'd0;
          #1;
          check("rstcnt_async_cnt", {29'd0, bus.out_counter}, 32'd0);
          check("rstcnt_clk_phase", {31'd0, bus.clk_1Hz}, {31'd0, model_clk()});
          #1;
          rst_cnt = 1'b1;
        end
        OP_RSTCLK: begin
          check("pre_rstclk_clk", {31'd0, bus.clk_1Hz}, {31'd0, model_clk()});
          #3;
          rst_clk = 1'b0;
          k_m     = 0;
          #1;
          check("rstclk_async_clk", {31'd0, bus.clk_1Hz}, 32'd0);
          check("rstclk_cnt_hold", {29'd0, bus.out_counter}, {29'd0, cnt_m});
          repeat (vecs[i].ncyc) run_cycle(vecs[i].en);
          rst_clk = 1'b1;
        end
        default: begin
        end
      endcase
      check($sformatf("vec%0d_cnt", i), {29'd0, bus.out_counter}, {29'd0, vecs[i].exp_cnt});
    end

    // Default ratio: far below one half-period, so nothing may move.
    repeat (30000) @(posedge clk);
    #1;
    check("dflt_clk_edges", dflt_edges, 32'd0);
    check("dflt_clk_1Hz", {31'd0, dflt_bus.clk_1Hz}, 32'd0);
    check("dflt_out_counter", {29'd0, dflt_bus.out_counter}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
